// File: rtl/ddc_uart_collector_pkg.sv
// Shared definitions for the DDC telemetry collector: packet framing constants,
// FSM encodings and the packet checksum helper.
package ddc_uart_collector_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         PKT_LEN       = 5;
  localparam int         DDC_CHANNELS  = 128;

  typedef enum logic [$clog2(PKT_LEN)-1:0] {
    P_HUNT = 3'd0,
    P_ADDR = 3'd1,
    P_DHI  = 3'd2,
    P_DLO  = 3'd3,
    P_CSUM = 3'd4
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [7:0] ddc_csum(input logic [7:0] addr,
                                          input logic [7:0] d_hi,
                                          input logic [7:0] d_lo);
    return addr ^ d_hi ^ d_lo;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-bit recheck at half bit,
// mid-bit sampling of data and stop bits.
module uart_rx_byte
  import ddc_uart_collector_pkg::*;
#(
  parameter int CLK_PER_BIT = 700
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iRx,
  output logic [7:0] oByte,
  output logic       oStrobe,
  output logic       oFrameErr
);

  localparam int            CW        = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  rx_state_e     r_state;
  rx_state_e     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          r_meta, r_sync, r_prev;
  logic [7:0]    r_shift, r_byte;
  logic          r_strobe, r_ferr;
  logic          w_half_end, w_bit_end, w_cnt_clr, w_shift_en, w_done, w_ferr;

  assign w_half_end = (r_cnt == HALF_LAST);
  assign w_bit_end  = (r_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:  w_state_next = (r_prev && !r_sync) ? RX_START : RX_IDLE;
      RX_START: begin
        if (w_half_end) begin
          w_state_next = r_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_state_next = RX_START;
        end
      end
      RX_DATA:  w_state_next = (w_bit_end && r_bit == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  w_state_next = w_bit_end ? RX_IDLE : RX_STOP;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr  = (r_state == RX_IDLE) || ((r_state == RX_START) && w_half_end) || w_bit_end;
    w_shift_en = (r_state == RX_DATA) && w_bit_end;
    w_done     = (r_state == RX_STOP) && w_bit_end && r_sync;
    w_ferr     = (r_state == RX_STOP) && w_bit_end && !r_sync;
  end

  // Synchroniser, bit timer and shift register; line registers reset to idle-high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_prev   <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_byte   <= 8'h00;
      r_strobe <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_meta   <= iRx;
      r_sync   <= r_meta;
      r_prev   <= r_sync;
      r_cnt    <= w_cnt_clr ? CW'(0) : r_cnt + CW'(1);
      if (r_state == RX_START) begin
        r_bit <= 3'd0;
      end else if (w_shift_en) begin
        r_bit <= r_bit + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_sync, r_shift[7:1]};
      end
      if (w_done) begin
        r_byte <= r_shift;
      end
      r_strobe <= w_done;
      r_ferr   <= w_ferr;
    end
  end

  assign oByte     = r_byte;
  assign oStrobe   = r_strobe;
  assign oFrameErr = r_ferr;

endmodule

// File: rtl/ddc_uart_collector.sv
// DDC telemetry collector: parses SYNC/ADDR/DHI/DLO/CSUM packets from UART into a
// 128 x 16 table and serves single-cycle-latency reads to the frame former.
module ddc_uart_collector
  import ddc_uart_collector_pkg::*;
#(
  parameter int         CLK_PER_BIT = 700,
  parameter int         GAP_TIMEOUT = 8064,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iRx,
  input  logic        iReq,
  input  logic [6:0]  iAddr,
  output logic [15:0] oData,
  output logic        oValid,
  output logic        oBusy,
  output logic        oFrameOk,
  output logic [7:0]  oErrCnt
);

  localparam int            GW       = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT);
  localparam logic [6:0]    CLR_LAST = 7'(DDC_CHANNELS - 1);

  logic [7:0]    w_rx_byte;
  logic          w_rx_strobe, w_rx_ferr;
  parse_state_e  r_state, w_state_next;
  logic [GW-1:0] r_gap;
  logic [6:0]    r_addr;
  logic [7:0]    r_dhi, r_dlo;
  logic          w_gap_hit, w_csum_ok, w_pkt_good, w_pkt_err, w_we;
  logic [6:0]    w_waddr;
  logic [15:0]   w_wdata;
  logic [15:0]   r_mem [DDC_CHANNELS];
  logic          r_busy, r_frame_ok, r_valid;
  logic [6:0]    r_clr_addr;
  logic [7:0]    r_err_cnt;
  logic [15:0]   r_data;

  uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .iRx       (iRx),
    .oByte     (w_rx_byte),
    .oStrobe   (w_rx_strobe),
    .oFrameErr (w_rx_ferr)
  );

  assign w_gap_hit = (r_gap == GAP_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= P_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rx_ferr) begin
      w_state_next = P_HUNT;
    end else if (w_rx_strobe) begin
      case (r_state)
        P_HUNT:  w_state_next = (w_rx_byte == SYNC_BYTE) ? P_ADDR : P_HUNT;
        P_ADDR:  w_state_next = w_rx_byte[7] ? P_HUNT : P_DHI;
        P_DHI:   w_state_next = P_DLO;
        P_DLO:   w_state_next = P_CSUM;
        P_CSUM:  w_state_next = P_HUNT;
        default: w_state_next = P_HUNT;
      endcase
    end else if (w_gap_hit) begin
      w_state_next = P_HUNT;
    end else begin
      w_state_next = r_state;
    end
  end

  // A timeout only counts when no byte event arrives in the same cycle
  always_comb begin
    w_csum_ok  = (w_rx_byte == ddc_csum({1'b0, r_addr}, r_dhi, r_dlo));
    w_pkt_good = w_rx_strobe && (r_state == P_CSUM) && w_csum_ok;
    w_pkt_err  = w_rx_ferr
              || (w_rx_strobe && (r_state == P_ADDR) && w_rx_byte[7])
              || (w_rx_strobe && (r_state == P_CSUM) && !w_csum_ok)
              || (!w_rx_strobe && !w_rx_ferr && w_gap_hit && (r_state != P_HUNT));
    w_we       = r_busy || w_pkt_good;
    w_waddr    = r_busy ? r_clr_addr : r_addr;
    w_wdata    = r_busy ? 16'h0000 : {r_dhi, r_dlo};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_gap  <= '0;
      r_addr <= 7'd0;
      r_dhi  <= 8'h00;
      r_dlo  <= 8'h00;
    end else begin
      if (w_rx_strobe || w_rx_ferr) begin
        r_gap <= GW'(0);
      end else if (!w_gap_hit) begin
        r_gap <= r_gap + GW'(1);
      end
      if (w_rx_strobe && r_state == P_ADDR) r_addr <= w_rx_byte[6:0];
      if (w_rx_strobe && r_state == P_DHI)  r_dhi  <= w_rx_byte;
      if (w_rx_strobe && r_state == P_DLO)  r_dlo  <= w_rx_byte;
    end
  end

  // Table storage: read-before-write falls out of the non-blocking read
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy     <= 1'b1;
      r_clr_addr <= 7'd0;
      r_frame_ok <= 1'b0;
      r_err_cnt  <= 8'h00;
      r_valid    <= 1'b0;
      r_data     <= 16'h0000;
    end else begin
      if (r_busy) begin
        r_clr_addr <= r_clr_addr + 7'd1;
        r_busy     <= (r_clr_addr != CLR_LAST);
      end
      r_frame_ok <= w_pkt_good && !r_busy;
      if (w_pkt_err && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      r_valid <= iReq;
      if (iReq) begin
        r_data <= r_busy ? 16'h0000 : r_mem[iAddr];
      end
    end
  end

  assign oData    = r_data;
  assign oValid   = r_valid;
  assign oBusy    = r_busy;
  assign oFrameOk = r_frame_ok;
  assign oErrCnt  = r_err_cnt;

endmodule

// File: tb/tb_ddc_uart_collector.sv
// Directed bench for ddc_uart_collector: UART packets at 16 clk/bit with
// hand-computed table contents, error counts and read results.
`timescale 1ns/1ps
module tb_ddc_uart_collector;

  localparam int CPB = 16;
  localparam int GAP = 8064;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iRx;
  logic        iReq;
  logic [6:0]  iAddr;
  logic [15:0] oData;
  logic        oValid, oBusy, oFrameOk;
  logic [7:0]  oErrCnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frame  = 0;
  int frame_ref;
  logic [7:0] tx_q[$];

  ddc_uart_collector #(.CLK_PER_BIT(CPB), .GAP_TIMEOUT(GAP), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .iRx      (iRx),
    .iReq     (iReq),
    .iAddr    (iAddr),
    .oData    (oData),
    .oValid   (oValid),
    .oBusy    (oBusy),
    .oFrameOk (oFrameOk),
    .oErrCnt  (oErrCnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oFrameOk === 1'b1) n_frame++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    iRx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      iRx = b[i];
      repeat (CPB) @(negedge clk);
    end
    iRx = stop_bit;
    repeat (CPB) @(negedge clk);
    if (!stop_bit) begin
      iRx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    tx_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [6:0] a, input logic [15:0] exp);
    iReq = 1'b1;
    iAddr = a;
    @(negedge clk);
    iReq = 1'b0;
    check_eq({tag, "_valid"}, 32'(oValid), 32'd1);
    check_eq({tag, "_data"}, 32'(oData), 32'(exp));
    @(negedge clk);
    check_eq({tag, "_valid_off"}, 32'(oValid), 32'd0);
    check_eq({tag, "_hold"}, 32'(oData), 32'(exp));
  endtask

  // Releases reset on the current falling edge and measures the clear sweep
  task automatic release_and_sweep(input string tag);
    int n;
    n = 0;
    reset_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (oBusy !== 1'b1) break;
      n++;
      if (k == 1) begin
        iReq = 1'b1;
        iAddr = 7'd5;
      end else if (k == 2) begin
        iReq = 1'b0;
        check_eq({tag, "_busy_rd_valid"}, 32'(oValid), 32'd1);
        check_eq({tag, "_busy_rd_data"}, 32'(oData), 32'd0);
      end
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 32'(n), 32'd128);
  endtask

  initial begin
    reset_n = 1'b0;
    iRx = 1'b1;
    iReq = 1'b0;
    iAddr = 7'd0;
    repeat (5) @(negedge clk);
    check_eq("rst_data", 32'(oData), 32'd0);
    check_eq("rst_valid", 32'(oValid), 32'd0);
    check_eq("rst_busy", 32'(oBusy), 32'd1);
    check_eq("rst_frameok", 32'(oFrameOk), 32'd0);
    check_eq("rst_errcnt", 32'(oErrCnt), 32'd0);

    // 1: clear sweep
    release_and_sweep("t1");
    repeat (4) @(negedge clk);

    // 2: good packet to channel 5
    frame_ref = n_frame;
    tx_q = {8'hA5, 8'h05, 8'h12, 8'h34, 8'h23};
    send_q();
    check_eq("t2_frames", 32'(n_frame - frame_ref), 32'd1);
    check_eq("t2_errcnt", 32'(oErrCnt), 32'd0);
    read_chk("t2_rd5", 7'd5, 16'h1234);

    // 3: bad checksum
    frame_ref = n_frame;
    tx_q = {8'hA5, 8'h05, 8'h12, 8'h34, 8'h00};
    send_q();
    check_eq("t3_frames", 32'(n_frame - frame_ref), 32'd0);
    check_eq("t3_errcnt", 32'(oErrCnt), 32'd1);
    read_chk("t3_rd5", 7'd5, 16'h1234);

    // 4: junk then good packet to channel 7F (7F^AB^CD = 19)
    frame_ref = n_frame;
    tx_q = {8'h00, 8'hFF, 8'hA5, 8'h7F, 8'hAB, 8'hCD, 8'h19};
    send_q();
    check_eq("t4_frames", 32'(n_frame - frame_ref), 32'd1);
    check_eq("t4_errcnt", 32'(oErrCnt), 32'd1);
    iReq = 1'b1;
    iAddr = 7'd5;
    @(negedge clk);
    iAddr = 7'h7F;
    check_eq("t4_b2b0_valid", 32'(oValid), 32'd1);
    check_eq("t4_b2b0_data", 32'(oData), 32'h1234);
    @(negedge clk);
    iReq = 1'b0;
    check_eq("t4_b2b1_valid", 32'(oValid), 32'd1);
    check_eq("t4_b2b1_data", 32'(oData), 32'hABCD);
    @(negedge clk);

    // 5: inter-byte gap timeout, then good packet to channel 6
    frame_ref = n_frame;
    tx_q = {8'hA5, 8'h05, 8'h12};
    send_q();
    repeat (GAP + 1) @(negedge clk);
    check_eq("t5_errcnt_gap", 32'(oErrCnt), 32'd2);
    tx_q = {8'hA5, 8'h06, 8'h00, 8'h01, 8'h07};
    send_q();
    check_eq("t5_frames", 32'(n_frame - frame_ref), 32'd1);
    check_eq("t5_errcnt", 32'(oErrCnt), 32'd2);
    read_chk("t5_rd6", 7'd6, 16'h0001);
    read_chk("t5_rd5", 7'd5, 16'h1234);

    // 6: framing error on DHI, saturation, reset mid-packet
    frame_ref = n_frame;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("t6_ferr_frames", 32'(n_frame - frame_ref), 32'd0);
    check_eq("t6_ferr_errcnt", 32'(oErrCnt), 32'd3);
    read_chk("t6_rd6", 7'd6, 16'h0001);
    for (int i = 0; i < 250; i++) send_byte(8'hFF, 1'b0);
    check_eq("t6_errcnt_253", 32'(oErrCnt), 32'd253);
    for (int i = 0; i < 50; i++) send_byte(8'hFF, 1'b0);
    check_eq("t6_errcnt_sat", 32'(oErrCnt), 32'd255);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_rst_errcnt", 32'(oErrCnt), 32'd0);
    check_eq("t6_rst_busy", 32'(oBusy), 32'd1);
    release_and_sweep("t6");
    frame_ref = n_frame;
    tx_q = {8'h12, 8'h34, 8'h23};
    send_q();
    check_eq("t6_post_frames", 32'(n_frame - frame_ref), 32'd0);
    check_eq("t6_post_errcnt", 32'(oErrCnt), 32'd0);
    read_chk("t6_rd5", 7'd5, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
